conv2d_frame_sched: RTL and testbench

// Frame-level sequencer for the 3x3 line-buffered convolution engine. Accepts one
// IMG_W x IMG_H raster frame on a valid/ready stream and clears the engine before

---
 rtl/conv2d_frame_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_conv2d_frame_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_frame_sched.sv
// conv2d_frame_sched
// Frame-level sequencer for a 3x3 line-buffered convolution engine.
// Each frame is handled in this order:
//   1. Clear the engine.
//   2. Stream one IMG_W x IMG_H raster frame into it.
//   3. Flush it with WIN_LAT dummy beats.
//   4. Forward only the full-window results, tagged with SOF/EOL/EOF.
module conv2d_frame_sched #(
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128,
    parameter int PIXEL_BITS = 8,
    parameter int WIN_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [PIXEL_BITS-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  eng_clr_n,
    output logic [PIXEL_BITS-1:0] eng_pixel,
    output logic                  eng_valid,
    input  logic [PIXEL_BITS-1:0] eng_out_pixel,
    input  logic                  eng_out_valid,
    output logic [PIXEL_BITS-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LW = $clog2(WIN_LAT + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(2);
    localparam logic [RW-1:0] ROW_WIN  = RW'(2);
    localparam logic [LW-1:0] LAT_MAX  = LW'(WIN_LAT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    // Input raster position (next pixel expected from the stream).
    logic [CW-1:0] in_col_reg;
    logic [RW-1:0] in_row_reg;

    // Number of dummy flush beats already issued.
    logic [LW-1:0] flush_cnt_reg;

    // Engine output tracking: warm-up beat discard count and output raster position.
    logic [LW-1:0] disc_cnt_reg;
    logic [CW-1:0] o_col_reg;
    logic [RW-1:0] o_row_reg;

    // Registered result stream.
    logic [PIXEL_BITS-1:0] m_data_reg;
    logic                  m_valid_reg;
    logic                  m_sof_reg;
    logic                  m_eol_reg;
    logic                  m_eof_reg;

    logic in_hs;
    logic in_last;
    logic flush_active;
    logic track_en;
    logic beat_kept;
    logic fwd;
    logic o_col_last;
    logic o_row_last;

    assign in_hs        = (state_reg == ST_RUN) && s_valid;
    assign in_last      = (in_col_reg == COL_LAST) && (in_row_reg == ROW_LAST);
    assign flush_active = (state_reg == ST_FLUSH) && (flush_cnt_reg < LAT_MAX);

    // Engine results only mean something between the clear and the end of flush.
    assign track_en   = ((state_reg == ST_RUN) || (state_reg == ST_FLUSH)) && eng_out_valid;
    assign beat_kept  = track_en && (disc_cnt_reg == LAT_MAX);
    assign o_col_last = (o_col_reg == COL_LAST);
    assign o_row_last = (o_row_reg == ROW_LAST);

    // A window is complete once two full rows and two full columns precede it.
    assign fwd = beat_kept && (o_row_reg >= ROW_WIN) && (o_col_reg >= COL_WIN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and Moore/pass-through outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        done       = 1'b0;
        s_ready    = 1'b0;
        eng_clr_n  = 1'b1;
        eng_valid  = 1'b0;
        eng_pixel  = '0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                eng_clr_n  = 1'b0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                s_ready   = 1'b1;
                eng_valid = s_valid;
                eng_pixel = s_data;
                if (in_hs && in_last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                eng_valid = flush_active;
                // The last result leaves one cycle after the final flush beat
                // returns, so m_eof cannot appear while flush beats remain.
                if (!flush_active && m_eof_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Input raster counters advance on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col_reg <= '0;
            in_row_reg <= '0;
        end else if (state_reg == ST_CLEAR) begin
            in_col_reg <= '0;
            in_row_reg <= '0;
        end else if (in_hs) begin
            if (in_col_reg == COL_LAST) begin
                in_col_reg <= '0;
                in_row_reg <= (in_row_reg == ROW_LAST) ? '0 : in_row_reg + 1'b1;
            end else begin
                in_col_reg <= in_col_reg + 1'b1;
            end
        end
    end

    // Flush beat counter: WIN_LAT back-to-back dummy beats after the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_reg <= '0;
        end else if (state_reg == ST_CLEAR) begin
            flush_cnt_reg <= '0;
        end else if (flush_active) begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    // Output tracking: skip the engine warm-up beats, then follow the raster
    // position of the pixel whose window each result represents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disc_cnt_reg <= '0;
            o_col_reg    <= '0;
            o_row_reg    <= '0;
        end else if (state_reg == ST_CLEAR) begin
            disc_cnt_reg <= '0;
            o_col_reg    <= '0;
            o_row_reg    <= '0;
        end else if (track_en) begin
            if (disc_cnt_reg < LAT_MAX) begin
                disc_cnt_reg <= disc_cnt_reg + 1'b1;
            end else if (o_col_last) begin
                o_col_reg <= '0;
                o_row_reg <= o_row_last ? '0 : o_row_reg + 1'b1;
            end else begin
                o_col_reg <= o_col_reg + 1'b1;
            end
        end
    end

    // Result register: one cycle after a qualifying engine beat, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_reg  <= '0;
            m_valid_reg <= 1'b0;
            m_sof_reg   <= 1'b0;
            m_eol_reg   <= 1'b0;
            m_eof_reg   <= 1'b0;
        end else begin
            m_valid_reg <= fwd;
            m_data_reg  <= fwd ? eng_out_pixel : '0;
            m_sof_reg   <= fwd && (o_row_reg == ROW_WIN) && (o_col_reg == COL_WIN);
            m_eol_reg   <= fwd && o_col_last;
            m_eof_reg   <= fwd && o_col_last && o_row_last;
        end
    end

    assign m_data  = m_data_reg;
    assign m_valid = m_valid_reg;
    assign m_sof   = m_sof_reg;
    assign m_eol   = m_eol_reg;
    assign m_eof   = m_eof_reg;

endmodule

// File: tb/tb_conv2d_frame_sched.sv
// Bench for conv2d_frame_sched with a 4x4 frame and WIN_LAT=2.
// A simple engine model echoes each pixel WIN_LAT beats later.
// The expected results come straight from the frame geometry.
module tb_conv2d_frame_sched;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int PB   = 8;
    localparam int WL   = 2;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [PB-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          eng_clr_n;
    logic [PB-1:0] eng_pixel;
    logic          eng_valid;
    logic [PB-1:0] eng_out_pixel;
    logic          eng_out_valid;
    logic [PB-1:0] m_data;
    logic          m_valid;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;

    always #5 clk = ~clk;

    conv2d_frame_sched #(
        .IMG_W(W), .IMG_H(H), .PIXEL_BITS(PB), .WIN_LAT(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .eng_clr_n(eng_clr_n), .eng_pixel(eng_pixel), .eng_valid(eng_valid),
        .eng_out_pixel(eng_out_pixel), .eng_out_valid(eng_out_valid),
        .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
    );

    // Engine model: output one cycle after each beat, echoing the beat WL earlier.
    logic [PB-1:0] hist [0:63];
    int            eng_beat;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_beat      <= 0;
            eng_out_valid <= 1'b0;
            eng_out_pixel <= '0;
        end else if (!eng_clr_n) begin
            eng_beat      <= 0;
            eng_out_valid <= 1'b0;
            eng_out_pixel <= '0;
        end else begin
            eng_out_valid <= eng_valid;
            if (eng_valid) begin
                hist[eng_beat % 64] <= eng_pixel;
                eng_out_pixel <= (eng_beat >= WL) ? hist[(eng_beat - WL) % 64] : '0;
                eng_beat      <= eng_beat + 1;
            end
        end
    end

    // Monitor, sampled on the falling edge.
    int   cyc_cnt  = 0;
    int   done_cnt = 0;
    int   ev_cnt   = 0;
    int   clr_cnt  = 0;
    int   eof_cnt  = 0;
    int   eof_cyc  = 0;
    int   done_cyc = 0;
    logic hs_flag  = 1'b0;
    int   got_d[$];
    int   got_f[$];
    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        hs_flag <= s_valid && s_ready;
        if (m_valid) begin
            got_d.push_back(int'(m_data));
            got_f.push_back(int'({m_sof, m_eol, m_eof}));
        end
        if (m_eof) begin
            eof_cnt <= eof_cnt + 1;
            eof_cyc <= cyc_cnt;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc_cnt;
        end
        if (eng_valid) ev_cnt <= ev_cnt + 1;
        if (!eng_clr_n) clr_cnt <= clr_cnt + 1;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [PB-1:0] pix [0:NPIX-1];

    task automatic fill_pix(input bit ramp);
        for (int i = 0; i < NPIX; i++) pix[i] = ramp ? PB'(i) : PB'($urandom_range(0, 255));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_s_ready"}, s_ready, 0);
        check_val({tag, "_eng_valid"}, eng_valid, 0);
        check_val({tag, "_eng_pixel"}, eng_pixel, 0);
        check_val({tag, "_eng_clr_n"}, eng_clr_n, 1);
        check_val({tag, "_m_valid"}, m_valid, 0);
        check_val({tag, "_m_data"}, m_data, 0);
        check_val({tag, "_m_flags"}, {m_sof, m_eol, m_eof}, 0);
    endtask

    // Expected results: every pixel with at least two rows and two columns before it.
    task automatic compare_results(input int base, input int fno);
        int n;
        n = base;
        for (int q = 0; q < NPIX; q++) begin
            int r, c;
            r = q / W;
            c = q % W;
            if (r >= 2 && c >= 2) begin
                int ef;
                ef = ((r == 2 && c == 2) ? 4 : 0) + ((c == W - 1) ? 2 : 0) +
                     ((r == H - 1 && c == W - 1) ? 1 : 0);
                if (n < got_d.size()) begin
                    check_val($sformatf("f%0d_data_q%0d", fno, q), got_d[n], int'(pix[q]));
                    check_val($sformatf("f%0d_flags_q%0d", fno, q), got_f[n], ef);
                    $display("frame %0d result q=%0d data=%0d flags=%0b", fno, q, got_d[n], got_f[n]);
                end
                n++;
            end
        end
        check_val($sformatf("f%0d_result_count", fno), got_d.size() - base, (W - 2) * (H - 2));
    endtask

    // Runs one frame: cycle 0 pulses start.
    // gap_mode: 0 = s_valid held, 1 = every other cycle, 2 = random.
    // abort_at > 0 asserts rst_n once that many pixels have been accepted.
    task automatic run_frame(input int fno, input int gap_mode, input bit extra_starts,
                             input int abort_at, input int idle_after);
        int idx, base_done, base_ev, base_clr, base_got;
        bit fin, fstart;
        idx = 0; fin = 0; fstart = 0;
        base_done = done_cnt; base_ev = ev_cnt; base_clr = clr_cnt; base_got = got_d.size();
        for (int cyc = 0; cyc < 300; cyc++) begin
            start = (cyc == 0);
            if (extra_starts && cyc == 8) start = 1'b1;
            if (extra_starts && idx == NPIX && !fstart) begin
                start  = 1'b1;
                fstart = 1'b1;
            end
            if (idx < NPIX) begin
                s_data = pix[idx];
                case (gap_mode)
                    0:       s_valid = 1'b1;
                    1:       s_valid = (cyc % 2 == 0);
                    default: s_valid = ($urandom_range(0, 3) != 0);
                endcase
            end else begin
                s_valid = 1'b0;
                s_data  = PB'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            if (hs_flag) idx++;
            if (abort_at > 0 && idx == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                return;
            end
            if (done_cnt > base_done) begin
                fin = 1;
                break;
            end
        end
        start   = 1'b0;
        s_valid = 1'b0;
        check_val($sformatf("f%0d_completed", fno), fin, 1);
        check_val($sformatf("f%0d_pixels_accepted", fno), idx, NPIX);
        check_val($sformatf("f%0d_eng_beats", fno), ev_cnt - base_ev, NPIX + WL);
        check_val($sformatf("f%0d_clr_cycles", fno), clr_cnt - base_clr, 1);
        check_val($sformatf("f%0d_done_after_eof", fno), done_cyc - eof_cyc, 1);
        compare_results(base_got, fno);
        if (idle_after > 0) begin
            repeat (idle_after) begin
                @(posedge clk); #1;
            end
            check_val($sformatf("f%0d_done_pulses", fno), done_cnt - base_done, 1);
            check_val($sformatf("f%0d_idle_busy", fno), busy, 0);
        end
    endtask

    initial begin
        int eof_base, done_base, got_base;
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;

        // Ramp frame with s_valid held.
        fill_pix(1);
        run_frame(1, 0, 0, 0, 4);

        // Same frame with a bubble every other cycle.
        run_frame(2, 1, 0, 0, 4);

        // Stray start pulses during RUN and FLUSH are ignored.
        fill_pix(0);
        run_frame(3, 0, 1, 0, 4);

        // Reset mid-frame after pixel 9, then a clean frame.
        fill_pix(1);
        eof_base  = eof_cnt;
        done_base = done_cnt;
        got_base  = got_d.size();
        s_valid   = 1'b1;
        run_frame(4, 0, 0, 10, 0);
        @(negedge clk);
        check_idle_outputs("abort");
        @(posedge clk); #1;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_val("abort_no_eof", eof_cnt - eof_base, 0);
        check_val("abort_no_done", done_cnt - done_base, 0);
        check_val("abort_no_results", got_d.size() - got_base, 0);
        run_frame(5, 0, 0, 0, 4);

        // Back-to-back frames, the second started one cycle after done.
        done_base = done_cnt;
        run_frame(6, 0, 0, 0, 0);
        run_frame(7, 0, 0, 0, 4);
        check_val("b2b_done_pulses", done_cnt - done_base, 2);

        // Random pixels with random s_valid gaps.
        for (int f = 0; f < 3; f++) begin
            fill_pix(0);
            run_frame(8 + f, 2, 0, 0, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
